// File: rtl/digdug_spattr_buf.sv
// Sprite attribute buffer: three CPU-writable 128x8 banks, snapshotted into a 128x24 display RAM on each VBLK rise.
// Latency: CPU_DO and SPATDT are 1 cycle after address; a full copy holds BUSY for 129 cycles, D[k] lands at START+2+k.
// Backpressure: none. CPU and renderer ports are never stalled, and a START during a copy is dropped, not queued.
//
// Ports:
//   RCLK, RESET_N         : clock, synchronous active-low reset
//   CPU_BK/AD/WR/DI/DO    : CPU byte port into working banks (bank 3 unmapped, reads 8'hFF)
//   VBLK                  : vertical-blank level, rising edge requests a copy
//   SPATAD/SPATDT         : renderer read port into display RAM, word = {bank2, bank1, bank0}
//   BUSY                  : copy in progress
module digdug_spattr_buf (
    input  logic        RCLK,
    input  logic        RESET_N,
    input  logic [1:0]  CPU_BK,
    input  logic [6:0]  CPU_AD,
    input  logic        CPU_WR,
    input  logic [7:0]  CPU_DI,
    output logic [7:0]  CPU_DO,
    input  logic        VBLK,
    input  logic [6:0]  SPATAD,
    output logic [23:0] SPATDT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [7:0]  w0_ram [128];
    logic [7:0]  w1_ram [128];
    logic [7:0]  w2_ram [128];
    logic [23:0] d_ram  [128];

    logic        vblk_d;
    logic        vblk_vld;   // vblk_d holds a real post-reset sample
    logic        start;
    logic        rd_en;
    logic        cnt_clr;
    logic [7:0]  rcnt;
    logic [6:0]  wcnt;
    logic        wr_vld;
    logic [7:0]  rd0_dat;
    logic [7:0]  rd1_dat;
    logic [7:0]  rd2_dat;

    // The first edge after reset compares VBLK against the reset value of
    // vblk_d, not a real sample, so it cannot count as a low->high transition.
    assign start = VBLK & ~vblk_d & vblk_vld;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COPY;
                    cnt_clr = 1'b1;
                end
            end
            ST_COPY: begin
                rd_en = 1'b1;
                // Reading the last entry: rcnt steps to 128 on this edge.
                if (rcnt == 8'd127) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge RCLK) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            BUSY     <= 1'b0;
            rcnt     <= 8'd0;
            wcnt     <= 7'd0;
            wr_vld   <= 1'b0;
            vblk_d   <= 1'b0;
            vblk_vld <= 1'b0;
            CPU_DO   <= 8'h00;
            SPATDT   <= 24'h0;
        end else begin
            state_q  <= state_d;
            // Registered off the state so BUSY covers exactly the read and
            // write-back cycles: START+1 through START+129.
            BUSY     <= (state_q != ST_IDLE);
            vblk_d   <= VBLK;
            vblk_vld <= 1'b1;
            wr_vld   <= rd_en;
            if (cnt_clr) begin
                rcnt <= 8'd0;
            end else if (rd_en) begin
                rcnt <= rcnt + 8'd1;
            end
            if (rd_en) begin
                wcnt <= rcnt[6:0];
            end
            case (CPU_BK)
                2'd0:    CPU_DO <= w0_ram[CPU_AD];
                2'd1:    CPU_DO <= w1_ram[CPU_AD];
                2'd2:    CPU_DO <= w2_ram[CPU_AD];
                default: CPU_DO <= 8'hFF;
            endcase
            // Reads the pre-edge contents, so a same-cycle copy write to the
            // same entry returns the old word.
            SPATDT <= d_ram[SPATAD];
        end
    end

    // RAM arrays carry no reset. Reads here see the pre-edge contents, so a
    // CPU write colliding with the copy read lands in W only.
    always_ff @(posedge RCLK) begin
        if (CPU_WR) begin
            case (CPU_BK)
                2'd0:    w0_ram[CPU_AD] <= CPU_DI;
                2'd1:    w1_ram[CPU_AD] <= CPU_DI;
                2'd2:    w2_ram[CPU_AD] <= CPU_DI;
                default: ;
            endcase
        end
        if (rd_en) begin
            rd0_dat <= w0_ram[rcnt[6:0]];
            rd1_dat <= w1_ram[rcnt[6:0]];
            rd2_dat <= w2_ram[rcnt[6:0]];
        end
        // A reset mid-copy suppresses the pending write-back; entries already
        // written stay as they are.
        if (RESET_N && wr_vld) begin
            d_ram[wcnt] <= {rd2_dat, rd1_dat, rd0_dat};
        end
    end

endmodule

// File: tb/tb_digdug_spattr_buf.sv
module tb_digdug_spattr_buf;

    logic        RCLK = 1'b0;
    logic        RESET_N;
    logic [1:0]  CPU_BK;
    logic [6:0]  CPU_AD;
    logic        CPU_WR;
    logic [7:0]  CPU_DI;
    logic [7:0]  CPU_DO;
    logic        VBLK;
    logic [6:0]  SPATAD;
    logic [23:0] SPATDT;
    logic        BUSY;

    always #5 RCLK = ~RCLK;

    digdug_spattr_buf dut (
        .RCLK    (RCLK),
        .RESET_N (RESET_N),
        .CPU_BK  (CPU_BK),
        .CPU_AD  (CPU_AD),
        .CPU_WR  (CPU_WR),
        .CPU_DI  (CPU_DI),
        .CPU_DO  (CPU_DO),
        .VBLK    (VBLK),
        .SPATAD  (SPATAD),
        .SPATDT  (SPATDT),
        .BUSY    (BUSY)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: working banks, display RAM, and a copy described only
    // by its timeline (entry k sampled at START+1+k, visible in D at START+2+k).
    logic [7:0]  mw0 [128];
    logic [7:0]  mw1 [128];
    logic [7:0]  mw2 [128];
    bit          wk0 [128];
    bit          wk1 [128];
    bit          wk2 [128];
    logic [23:0] md   [128];
    bit          dk   [128];
    logic [23:0] snap [128];
    bit          sk   [128];
    bit          active = 1'b0;
    int          cyc    = 0;
    int          e0     = 0;
    bit          vd     = 1'b0;
    bit          vd_k   = 1'b0;
    bit          m_busy = 1'b0;
    logic [7:0]  m_do   = 8'h00;
    bit          m_do_k = 1'b0;
    logic [23:0] m_sp   = 24'h0;
    bit          m_sp_k = 1'b0;

    logic [7:0]  oldd [128];
    logic [7:0]  newv [128];
    int          busy_n;
    int          fall;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int          rel;
        int          k;
        bit          was;
        logic [23:0] n_sp;
        bit          n_sp_k;
        logic [7:0]  n_do;
        bit          n_do_k;
        cyc++;
        if (!RESET_N) begin
            m_busy = 1'b0;
            m_do   = 8'h00; m_do_k = 1'b1;
            m_sp   = 24'h0; m_sp_k = 1'b1;
            active = 1'b0;
            vd     = 1'b0;  vd_k   = 1'b0;
        end else begin
            n_sp   = md[SPATAD];
            n_sp_k = dk[SPATAD];
            case (CPU_BK)
                2'd0:    begin n_do = mw0[CPU_AD]; n_do_k = wk0[CPU_AD]; end
                2'd1:    begin n_do = mw1[CPU_AD]; n_do_k = wk1[CPU_AD]; end
                2'd2:    begin n_do = mw2[CPU_AD]; n_do_k = wk2[CPU_AD]; end
                default: begin n_do = 8'hFF;       n_do_k = 1'b1;        end
            endcase
            was = active;
            rel = cyc - e0;
            if (active) begin
                if (rel >= 1 && rel <= 128) begin
                    k = rel - 1;
                    snap[k] = {mw2[k], mw1[k], mw0[k]};
                    sk[k]   = wk0[k] && wk1[k] && wk2[k];
                end
                if (rel >= 2 && rel <= 129) begin
                    k = rel - 2;
                    md[k] = snap[k];
                    dk[k] = sk[k];
                end
                m_busy = (rel >= 1 && rel <= 129);
                if (rel >= 129) active = 1'b0;
            end else begin
                m_busy = 1'b0;
            end
            if (VBLK && vd_k && !vd && !was) begin
                active = 1'b1;
                e0     = cyc;
            end
            vd = VBLK; vd_k = 1'b1;
            m_sp = n_sp; m_sp_k = n_sp_k;
            m_do = n_do; m_do_k = n_do_k;
        end
        if (CPU_WR) begin
            case (CPU_BK)
                2'd0:    begin mw0[CPU_AD] = CPU_DI; wk0[CPU_AD] = 1'b1; end
                2'd1:    begin mw1[CPU_AD] = CPU_DI; wk1[CPU_AD] = 1'b1; end
                2'd2:    begin mw2[CPU_AD] = CPU_DI; wk2[CPU_AD] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic step();
        @(posedge RCLK);
        model_edge();
        #1;
        chk("busy", {23'd0, BUSY}, {23'd0, m_busy});
        if (m_do_k) chk("cpu_do", {16'd0, CPU_DO}, {16'd0, m_do});
        if (m_sp_k) chk("spatdt", SPATDT, m_sp);
    endtask

    task automatic idle_rand();
        CPU_WR = 1'b0;
        CPU_BK = 2'($urandom_range(3, 0));
        CPU_AD = 7'($urandom_range(127, 0));
        SPATAD = 7'($urandom_range(127, 0));
    endtask

    task automatic traffic_rand();
        idle_rand();
        CPU_WR = ($urandom_range(1, 0) == 1);
        CPU_DI = 8'($urandom);
    endtask

    initial begin
        for (int a = 0; a < 128; a++) begin
            wk0[a] = 1'b0; wk1[a] = 1'b0; wk2[a] = 1'b0;
            dk[a]  = 1'b0; sk[a]  = 1'b0;
        end
        RESET_N = 1'b0; VBLK = 1'b1;
        CPU_BK = 2'd0; CPU_AD = 7'd0; CPU_WR = 1'b0; CPU_DI = 8'h00; SPATAD = 7'd0;

        // Reset with VBLK already high
        step(); step();
        chk("rst_busy",   {23'd0, BUSY},   24'd0);
        chk("rst_spatdt", SPATDT,          24'h0);
        chk("rst_cpu_do", {16'd0, CPU_DO}, 24'd0);
        RESET_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_copy_after_rst", {23'd0, BUSY}, 24'd0);
        end

        // Fill all banks; fixed values at entries 5 and 10
        VBLK = 1'b0;
        for (int b = 0; b < 3; b++) begin
            for (int a = 0; a < 128; a++) begin
                CPU_WR = 1'b1; CPU_BK = 2'(b); CPU_AD = 7'(a);
                CPU_DI = 8'($urandom);
                if (a == 5)  CPU_DI = (b == 0) ? 8'h3C : (b == 1) ? 8'h80 : 8'h02;
                if (a == 10) CPU_DI = (b == 0) ? 8'h00 : (b == 1) ? 8'h11 : 8'h77;
                SPATAD = 7'($urandom_range(127, 0));
                step();
            end
        end

        // Basic copy
        VBLK = 1'b1; idle_rand(); step();
        busy_n = 0;
        for (int i = 1; i <= 200; i++) begin
            idle_rand(); step();
            if (BUSY) busy_n++;
        end
        chk("busy_cycles", 24'(busy_n), 24'd129);
        SPATAD = 7'd5; step();
        chk("basic_5", SPATDT, 24'h02803C);

        // Tear-free: W changes, D holds until next VBLK edge
        VBLK = 1'b0;
        CPU_WR = 1'b1; CPU_BK = 2'd0; CPU_AD = 7'd5; CPU_DI = 8'hFF; step();
        CPU_WR = 1'b0; SPATAD = 7'd5; step(); step();
        chk("tearfree_hold", SPATDT, 24'h02803C);
        VBLK = 1'b1; idle_rand(); step();
        for (int i = 1; i <= 135; i++) begin
            idle_rand(); step();
        end
        SPATAD = 7'd5; step();
        chk("tearfree_upd", SPATDT, 24'h0280FF);

        // Collisions at entry 10
        VBLK = 1'b0;
        CPU_WR = 1'b1; CPU_BK = 2'd0; CPU_AD = 7'd10; CPU_DI = 8'hC3; step();
        VBLK = 1'b1; idle_rand(); step();
        for (int i = 1; i <= 135; i++) begin
            idle_rand();
            if (i == 11) begin
                CPU_WR = 1'b1; CPU_BK = 2'd1; CPU_AD = 7'd10; CPU_DI = 8'h55;
            end
            if (i == 12) SPATAD = 7'd10;
            step();
            if (i == 12) chk("coll_rd_old", SPATDT, 24'h771100);
        end
        SPATAD = 7'd10; step();
        chk("coll_wr_old", SPATDT, 24'h7711C3);
        CPU_BK = 2'd1; CPU_AD = 7'd10; step();
        chk("coll_w1_new", {16'd0, CPU_DO}, 24'h000055);

        // Retrigger mid-copy, random CPU traffic throughout
        VBLK = 1'b0; idle_rand(); step();
        VBLK = 1'b1; idle_rand(); step();
        busy_n = 0; fall = 0;
        for (int i = 1; i <= 300; i++) begin
            traffic_rand();
            if (i == 50) VBLK = 1'b0;
            if (i == 51) VBLK = 1'b1;
            step();
            if (BUSY) busy_n++;
            if (!BUSY && fall == 0 && i > 1) fall = i;
        end
        chk("retrig_fall", 24'(fall),   24'd130);
        chk("retrig_once", 24'(busy_n), 24'd129);

        // Abort by reset at cycle 60
        VBLK = 1'b0;
        for (int a = 0; a < 128; a++) begin
            oldd[a] = md[a][7:0];
            newv[a] = ~oldd[a];
            CPU_WR = 1'b1; CPU_BK = 2'd0; CPU_AD = 7'(a); CPU_DI = newv[a];
            SPATAD = 7'($urandom_range(127, 0));
            step();
        end
        VBLK = 1'b1; idle_rand(); step();
        for (int i = 1; i <= 59; i++) begin
            idle_rand(); step();
        end
        RESET_N = 1'b0; idle_rand(); step();
        chk("abort_busy", {23'd0, BUSY}, 24'd0);
        RESET_N = 1'b1; step(); step();
        for (int a = 0; a < 128; a++) begin
            CPU_WR = 1'b0; SPATAD = 7'(a); step();
            chk("abort_d", {16'd0, SPATDT[7:0]}, {16'd0, (a < 58) ? newv[a] : oldd[a]});
        end

        // CPU port and bank 3
        CPU_WR = 1'b1; CPU_BK = 2'd2; CPU_AD = 7'd127; CPU_DI = 8'hA5; step();
        CPU_WR = 1'b0; step();
        chk("cpu_b2_127", {16'd0, CPU_DO}, 24'h0000A5);
        CPU_WR = 1'b1; CPU_BK = 2'd3; CPU_AD = 7'd127; CPU_DI = 8'h00; step();
        for (int b = 0; b < 4; b++) begin
            CPU_WR = 1'b0; CPU_BK = 2'(b); CPU_AD = 7'd127; step();
            if (b == 3) chk("cpu_b3_read", {16'd0, CPU_DO}, 24'h0000FF);
            if (b == 2) chk("cpu_b3_nowr", {16'd0, CPU_DO}, 24'h0000A5);
        end
        for (int i = 0; i < 40; i++) begin
            traffic_rand(); step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
